pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the 5-stage core. It replaces hand-written inter-stage registers such as ID/EX and EX/MEM with one block.
- Adds a valid/ready handshake.
- Adds hazard-unit stall and flush, with automatic bubble insertion (control zeroed).
- Adds saturating stall and flush event counters for performance debug.
- Carries a wide datapath payload and a narrower control payload. Only the control payload is zeroed on bubbles.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_stage_reg_if.sv | 25 ++
 rtl/pipe_sat_counter.sv | 25 ++
 rtl/pipe_stage_reg.sv | 139 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage core pipeline registers: stage field
// widths, ID/EX default payload sizes, control-bit positions, skid states.
package pipe_pkg;

  // Stage field widths
  localparam int REG_W   = 32;
  localparam int RIDX_W  = 5;
  localparam int ALUOP_W = 2;

  // ID/EX payload: rs value, rt value, immediate + rs/rt/rd indices
  localparam int IDEX_DATA_W = 3 * REG_W + 3 * RIDX_W;
  // ID/EX control: ALU op in the low bits, then six single-bit controls
  localparam int IDEX_CTRL_W = ALUOP_W + 6;

  // Control bit positions (ALU op occupies [ALUOP_W-1:0])
  localparam int ALUSRC  = 2;
  localparam int REGDST  = 3;
  localparam int MEMWR   = 4;
  localparam int MEMRD   = 5;
  localparam int DATASRC = 6;
  localparam int WRREG   = 7;

  // Occupancy of the stage when the skid entry is present
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_MAIN  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle around one pipeline stage register.
// master: upstream/downstream environment; slave: the stage itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W = pipe_pkg::IDEX_DATA_W,
  parameter int CTRL_W = pipe_pkg::IDEX_CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts cycles with i_inc=1, sticks at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = &r_cnt;

  // Count events, holding once the maximum value is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register with valid/ready handshake, hazard stall and
// flush (bubbles zero the control payload only) and saturating perf counters.
// Optional build macro SKID_BUF_EN adds a one-entry skid register so that
// in_ready no longer depends combinationally on out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = IDEX_DATA_W,
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_out_xfer = r_valid & bus.out_ready;
  assign w_in_xfer  = bus.in_valid & w_in_ready;

`ifdef SKID_BUF_EN
  skid_state_e       r_state;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  // Ready comes from the state register only; flush always drains the input
  assign w_in_ready = flush | (~stall & (r_state != SKID_FULL));

  // Main/skid occupancy FSM; under stall w_in_xfer is 0, so only draining moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SKID_EMPTY;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_ctrl      <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush) begin
      r_state     <= SKID_EMPTY;
      r_valid     <= 1'b0;
      r_ctrl      <= '0;
      r_skid_ctrl <= '0;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_in_xfer) begin
            r_state <= SKID_MAIN;
            r_valid <= 1'b1;
            r_data  <= bus.in_data;
            r_ctrl  <= bus.in_ctrl;
          end
        end
        SKID_MAIN: begin
          if (w_in_xfer && w_out_xfer) begin
            r_data <= bus.in_data;
            r_ctrl <= bus.in_ctrl;
          end else if (w_in_xfer) begin
            r_state     <= SKID_FULL;
            r_skid_data <= bus.in_data;
            r_skid_ctrl <= bus.in_ctrl;
          end else if (w_out_xfer) begin
            r_state <= SKID_EMPTY;
            r_valid <= 1'b0;
            r_ctrl  <= '0;
          end
        end
        SKID_FULL: begin
          if (w_out_xfer) begin
            r_state     <= SKID_MAIN;
            r_data      <= r_skid_data;
            r_ctrl      <= r_skid_ctrl;
            r_skid_ctrl <= '0;
          end
        end
        default: begin
          r_state <= SKID_EMPTY;
          r_valid <= 1'b0;
          r_ctrl  <= '0;
        end
      endcase
    end
  end
`else
  // Classic pipeline ready: free slot or the slot drains this cycle
  assign w_in_ready = flush | (~stall & (~r_valid | bus.out_ready));

  // Single-entry stage register: flush > stall > normal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (stall) begin
      if (w_out_xfer) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_data  <= bus.in_data;
      r_ctrl  <= bus.in_ctrl;
    end else if (w_out_xfer) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end
  end
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_ctrl  = r_ctrl;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (stall),
    .o_cnt (stall_cycles)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (flush),
    .o_cnt (flush_events)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg (ID/EX widths, 4-bit counters).
module tb_pipe_stage_reg;
  localparam int DW = 111;
  localparam int CW = 8;
  localparam int NW = 4;

  logic          clk;
  logic          rst;
  logic          stall;
  logic          flush;
  logic [NW-1:0] stall_cycles;
  logic [NW-1:0] flush_events;
  int            n_assert;
  int            n_fail;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .bus          (bus),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_ctrl   = '0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_out_ctrl", 128'(bus.out_ctrl), 128'(0));
    chk("rst_out_data", 128'(bus.out_data), 128'(0));
    chk("rst_stall_cnt", 128'(stall_cycles), 128'(0));
    chk("rst_flush_cnt", 128'(flush_events), 128'(0));
    tick();
    rst = 1'b0;
    tick();

    // Streaming 1..10 with out_ready=1
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      bus.in_data = DW'(i);
      bus.in_ctrl = CW'(i);
      #1;
      chk("stream_in_ready", 128'(bus.in_ready), 128'(1));
      tick();
      chk("stream_out_valid", 128'(bus.out_valid), 128'(1));
      chk("stream_out_data", 128'(bus.out_data), 128'(i));
      chk("stream_out_ctrl", 128'(bus.out_ctrl), 128'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_out_valid", 128'(bus.out_valid), 128'(0));
    chk("drain_out_ctrl", 128'(bus.out_ctrl), 128'(0));
    chk("drain_data_hold", 128'(bus.out_data), 128'(10));

    // Stall with bubble
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(32'h55);
    bus.in_ctrl   = 8'h3C;
    bus.out_ready = 1'b0;
    tick();
    chk("stall_load_ctrl", 128'(bus.out_ctrl), 128'h3C);
    bus.in_data   = DW'(32'h66);
    bus.in_ctrl   = 8'hFF;
    stall         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
    tick();
    chk("stall_bubble_valid", 128'(bus.out_valid), 128'(0));
    chk("stall_bubble_ctrl", 128'(bus.out_ctrl), 128'(0));
    chk("stall_data_hold", 128'(bus.out_data), 128'h55);
    chk("stall_cnt_1", 128'(stall_cycles), 128'(1));
    tick();
    tick();
    chk("stall_in_ready_3", 128'(bus.in_ready), 128'(0));
    chk("stall_hold_valid", 128'(bus.out_valid), 128'(0));
    stall        = 1'b0;
    bus.in_valid = 1'b0;
    chk("stall_cnt_3", 128'(stall_cycles), 128'(3));

    // Flush kills stored beat and incoming beat
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(32'h77);
    bus.in_ctrl   = 8'h11;
    bus.out_ready = 1'b0;
    tick();
    chk("flush_load_valid", 128'(bus.out_valid), 128'(1));
    flush       = 1'b1;
    bus.in_data = DW'(32'h99);
    bus.in_ctrl = 8'hFF;
    #1;
    chk("flush_in_ready", 128'(bus.in_ready), 128'(1));
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
    chk("flush_out_ctrl", 128'(bus.out_ctrl), 128'(0));
    chk("flush_data_hold", 128'(bus.out_data), 128'h77);
    chk("flush_cnt_1", 128'(flush_events), 128'(1));
    bus.out_ready = 1'b1;
    tick();
    chk("flush_no_beat", 128'(bus.out_valid), 128'(0));

    // Flush and stall together: flush wins, both counters step
    flush = 1'b1;
    stall = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    chk("both_flush_cnt", 128'(flush_events), 128'(2));
    chk("both_stall_cnt", 128'(stall_cycles), 128'(4));

    // Backpressure with A, B, C
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(32'hA);
    bus.in_ctrl   = 8'h0A;
    #1;
    chk("bp_ready_empty", 128'(bus.in_ready), 128'(1));
    tick();
    chk("bp_out_a", 128'(bus.out_data), 128'hA);
    bus.in_data = DW'(32'hB);
    bus.in_ctrl = 8'h0B;
`ifdef SKID_BUF_EN
    #1;
    chk("bp_ready_main", 128'(bus.in_ready), 128'(1));
    tick();
    chk("bp_hold_a", 128'(bus.out_data), 128'hA);
    chk("bp_ready_full", 128'(bus.in_ready), 128'(0));
    bus.in_data = DW'(32'hC);
    bus.in_ctrl = 8'h0C;
    tick();
    chk("bp_still_a", 128'(bus.out_data), 128'hA);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_full_rel", 128'(bus.in_ready), 128'(0));
    tick();
    chk("bp_out_b", 128'(bus.out_data), 128'hB);
    chk("bp_out_b_ctrl", 128'(bus.out_ctrl), 128'h0B);
    chk("bp_ready_after", 128'(bus.in_ready), 128'(1));
    tick();
    chk("bp_out_c", 128'(bus.out_data), 128'hC);
    chk("bp_out_c_ctrl", 128'(bus.out_ctrl), 128'h0C);
`else
    #1;
    chk("bp_ready_blocked", 128'(bus.in_ready), 128'(0));
    tick();
    chk("bp_hold_a", 128'(bus.out_data), 128'hA);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_rel", 128'(bus.in_ready), 128'(1));
    tick();
    chk("bp_out_b", 128'(bus.out_data), 128'hB);
    bus.in_data = DW'(32'hC);
    bus.in_ctrl = 8'h0C;
    tick();
    chk("bp_out_c", 128'(bus.out_data), 128'hC);
    chk("bp_out_c_ctrl", 128'(bus.out_ctrl), 128'h0C);
`endif
    bus.in_valid = 1'b0;
    tick();
    chk("bp_drained", 128'(bus.out_valid), 128'(0));

    // Saturation: 4 + 20 stalled cycles clamp at 15
    stall = 1'b1;
    repeat (20) tick();
    stall = 1'b0;
    chk("sat_stall_cnt", 128'(stall_cycles), 128'(15));
    chk("sat_flush_cnt", 128'(flush_events), 128'(2));

    // Asynchronous reset mid-stream
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(32'h5A);
    bus.in_ctrl   = 8'hA5;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 128'(bus.out_valid), 128'(1));
    chk("pre_rst_ctrl", 128'(bus.out_ctrl), 128'hA5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(bus.out_valid), 128'(0));
    chk("arst_ctrl", 128'(bus.out_ctrl), 128'(0));
    chk("arst_data", 128'(bus.out_data), 128'(0));
    chk("arst_stall_cnt", 128'(stall_cycles), 128'(0));
    chk("arst_flush_cnt", 128'(flush_events), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 128'(bus.out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
